lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width of the downstream word RAM (2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; transfer on req_valid&req_ready.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 word, 01 halfword, 1X byte.
REQ-008 SHALL have port req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores.
REQ-009 SHALL have port req_addr  input  ADDR_W+2  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 SHALL have port resp_rdata  output  32  extended load data, registered, valid with resp_valid.
REQ-013 SHALL have port resp_err  output  1  misaligned access flag, valid with resp_valid.
REQ-014 SHALL have port mem_w_en  output  1  word RAM write enable.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word RAM address (latched req_addr[ADDR_W+1:2]).
REQ-016 SHALL have port mem_data_in  output  32  word written to RAM.
REQ-017 SHALL have port mem_data_out  input  32  RAM read data; synchronous RAM, valid the cycle after mem_addr is sampled.

Function
REQ-018 SHALL latch addr, size, we, unsigned, wdata on handshake; inputs ignored otherwise.
REQ-019 SHALL use little-endian lanes: byte k = bits [8k+7:8k], half at addr[1] = bits [16*addr[1]+15:16*addr[1]].
REQ-020 SHALL flag misaligned: word with addr[1:0]!=0, half with addr[0]=1; bytes never misaligned.
REQ-021 SHALL implement FSM IDLE, RD, RD_WAIT, WR, RESP.
REQ-022 IDLE: handshake -> RESP if misaligned (resp_err=1, no RAM access); -> WR if word store; else -> RD.
REQ-023 RD: drive mem_addr, mem_w_en=0; -> RD_WAIT.
REQ-024 RD_WAIT: load -> capture lane-extracted, extended data into resp_rdata, -> RESP; sub-word store -> register mem_data_out with the selected lane(s) replaced by store data (other lanes unchanged), -> WR.
REQ-025 WR: mem_w_en=1 for exactly this cycle, mem_data_in = merged word (or req_wdata for word store); -> RESP.
REQ-026 RESP: resp_valid=1 one cycle, req_ready=0; -> IDLE; next request accepted no earlier than the following cycle.
REQ-027 Latency from handshake cycle T: load resp at T+3; word store T+2; sub-word store T+4; misaligned T+1.
REQ-028 resp_rdata SHALL hold its last value outside loads; stores and errors leave it unchanged; resp_err=0 on non-error responses.
REQ-029 mem_w_en SHALL be 0 in every state except WR; a word is never written without a completed read in a sub-word store.
REQ-030 Word load with req_unsigned set SHALL return the raw word.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_w_en=0, mem_addr=0, mem_data_in=0.
REQ-032 Reset mid-operation SHALL abort the access with no RAM write and no response.

Verification
REQ-033 RAM word 3 = 0x8899AABB; LB addr 0x0D -> resp at T+3, resp_rdata=0xFFFFFFAA; LBU -> 0x000000AA.
REQ-034 Same RAM; LH addr 0x0E -> 0xFFFF8899; LHU addr 0x0C -> 0x0000AABB.
REQ-035 SB wdata 0x11223344 addr 0x0E -> single mem_w_en pulse at T+3, mem_addr=3, word becomes 0x8844AABB, resp at T+4.
REQ-036 SW 0xDEADBEEF addr 0x10 -> mem_w_en at T+1, mem_addr=4, no RD cycle, resp at T+2.
REQ-037 LH addr 0x0D -> resp_valid, resp_err=1 at T+1, mem_w_en never high, resp_rdata unchanged.
REQ-038 SB issued, rst_n pulsed low during RD_WAIT -> mem_w_en stays 0, RAM word unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/half/word access to a 32-bit word RAM,
// with read-modify-write for sub-word stores and misalignment trapping.
module lsu_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mdata_q, mdata_d;
    logic              err_q, err_d;

    logic        hs;
    logic        misaligned;
    logic [31:0] lane_sh;
    logic [31:0] ld_data;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] merged;

    assign hs = req_valid & req_ready;

    always_comb begin
        misaligned = 1'b0;
        unique case (1'b1)
            req_size[1]:          misaligned = 1'b0;
            req_size == 2'b01:    misaligned = req_addr[0];
            default:              misaligned = |req_addr[1:0];
        endcase
    end

    // Lane extraction and sign/zero extension of the RAM read word
    always_comb begin
        lane_sh = '0;
        ld_data = mem_data_out;
        if (size_q[1]) begin
            lane_sh = mem_data_out >> {addr_q[1:0], 3'b000};
            ld_data = uns_q ? {24'b0, lane_sh[7:0]}
                            : {{24{lane_sh[7]}}, lane_sh[7:0]};
        end else if (size_q == 2'b01) begin
            lane_sh = mem_data_out >> {addr_q[1], 4'b0000};
            ld_data = uns_q ? {16'b0, lane_sh[15:0]}
                            : {{16{lane_sh[15]}}, lane_sh[15:0]};
        end
    end

    // Sub-word store merge; mdata_q holds the right-justified store data here
    always_comb begin
        mask = '0;
        ins  = '0;
        if (size_q[1]) begin
            mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            ins  = {24'b0, mdata_q[7:0]} << {addr_q[1:0], 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            ins  = {16'b0, mdata_q[15:0]} << {addr_q[1], 4'b0000};
        end
        merged = (mem_data_out & ~mask) | (ins & mask);
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        mdata_d = mdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    err_d = misaligned;
                    if (req_we) begin
                        mdata_d = req_wdata;
                    end
                    if (misaligned) begin
                        state_d = S_RESP;
                    end else if (req_we && req_size == 2'b00) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (we_q) begin
                    mdata_d = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            mdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            mdata_q <= mdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
        end else if (hs) begin
            addr_q <= req_addr;
            size_q <= req_size;
            we_q   <= req_we;
            uns_q  <= req_unsigned;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_err    = (state_q == S_RESP) & err_q;
    assign resp_rdata  = rdata_q;
    assign mem_w_en    = (state_q == S_WR);
    assign mem_addr    = addr_q[ADDR_W+1:2];
    assign mem_data_in = mdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a synchronous word RAM model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_w_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;

    logic        preload = 1'b1;
    logic [31:0] ram [0:63];

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.ADDR_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_w_en    (mem_w_en),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            ram[3] <= 32'h8899AABB;
        end else if (mem_w_en) begin
            ram[mem_addr] <= mem_data_in;
        end
        mem_data_out <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request; latencies are counted in cycles after handshake
    task automatic access(input string tag, input logic we,
                          input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] wd,
                          output int lat, output int wcyc,
                          output int wcnt, output logic [5:0] waddr,
                          output logic [31:0] rd, output logic er);
        int k;
        lat = -1;
        wcyc = -1;
        wcnt = 0;
        waddr = '0;
        rd = '0;
        er = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c > 1) chk({tag, "_busy"}, {31'b0, req_ready},
                           {31'b0, 1'b0});
            if (mem_w_en) begin
                wcnt++;
                wcyc = c;
                waddr = mem_addr;
            end
            if (resp_valid) begin
                lat = c;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        @(negedge clk);
        chk({tag, "_rv_drop"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    int lat, wcyc, wcnt;
    logic [5:0] waddr;
    logic [31:0] rd;
    logic er;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_wen", {31'b0, mem_w_en}, 32'd0);
        chk("rst_maddr", {26'b0, mem_addr}, 32'd0);
        chk("rst_mdin", mem_data_in, 32'd0);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        access("lb", 1'b0, 2'b10, 1'b0, 8'h0D, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lb_lat", lat, 32'd3);
        chk("lb_data", rd, 32'hFFFFFFAA);
        chk("lb_err", {31'b0, er}, 32'd0);
        chk("lb_wcnt", wcnt, 32'd0);

        access("lbu", 1'b0, 2'b10, 1'b1, 8'h0D, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lbu_data", rd, 32'h000000AA);

        access("lh", 1'b0, 2'b01, 1'b0, 8'h0E, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lh_lat", lat, 32'd3);
        chk("lh_data", rd, 32'hFFFF8899);

        access("lhu", 1'b0, 2'b01, 1'b1, 8'h0C, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lhu_data", rd, 32'h0000AABB);

        access("lwu", 1'b0, 2'b00, 1'b1, 8'h0C, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lwu_lat", lat, 32'd3);
        chk("lwu_data", rd, 32'h8899AABB);

        access("sb", 1'b1, 2'b10, 1'b0, 8'h0E, 32'h11223344,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("sb_lat", lat, 32'd4);
        chk("sb_wcyc", wcyc, 32'd3);
        chk("sb_wcnt", wcnt, 32'd1);
        chk("sb_waddr", {26'b0, waddr}, 32'd3);
        chk("sb_err", {31'b0, er}, 32'd0);
        chk("sb_ram", ram[3], 32'h8844AABB);
        chk("sb_rdata_hold", resp_rdata, 32'h8899AABB);

        access("sw", 1'b1, 2'b00, 1'b0, 8'h10, 32'hDEADBEEF,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("sw_lat", lat, 32'd2);
        chk("sw_wcyc", wcyc, 32'd1);
        chk("sw_wcnt", wcnt, 32'd1);
        chk("sw_waddr", {26'b0, waddr}, 32'd4);
        chk("sw_ram", ram[4], 32'hDEADBEEF);

        access("lh_mis", 1'b0, 2'b01, 1'b0, 8'h0D, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("mis_lat", lat, 32'd1);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_wcnt", wcnt, 32'd0);
        chk("mis_rdata", rd, 32'h8899AABB);

        access("sw_mis", 1'b1, 2'b00, 1'b0, 8'h11, 32'h12345678,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("swm_lat", lat, 32'd1);
        chk("swm_err", {31'b0, er}, 32'd1);
        chk("swm_wcnt", wcnt, 32'd0);
        chk("swm_ram", ram[4], 32'hDEADBEEF);

        access("sh", 1'b1, 2'b01, 1'b0, 8'h12, 32'h0000CAFE,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("sh_lat", lat, 32'd4);
        chk("sh_ram", ram[4], 32'hCAFEBEEF);

        access("lb3", 1'b0, 2'b11, 1'b0, 8'h13, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("lb3_data", rd, 32'hFFFFFFCA);

        // SB aborted by reset while in RD_WAIT
        req_we = 1'b1;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 8'h0C;
        req_wdata = 32'h00000055;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wcnt = 0;
        lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_wen", {31'b0, mem_w_en}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_w_en) wcnt++;
            if (resp_valid) lat++;
        end
        chk("abort_wcnt", wcnt, 32'd0);
        chk("abort_resp", lat, 32'd0);
        chk("abort_ram", ram[3], 32'h8844AABB);
        chk("abort_rdy", {31'b0, req_ready}, 32'd1);

        access("lw_post", 1'b0, 2'b00, 1'b0, 8'h0C, 32'h0,
               lat, wcyc, wcnt, waddr, rd, er);
        chk("post_data", rd, 32'h8844AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
